// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: FSM state encoding and counter widths shared by the FIFO-fed UART transmitter
package fifo_uart_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
    localparam int FRAME_CNT_W = 16;
    localparam int BAUD_CNT_W = 16;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port; master is the transmitter, slave is the FIFO
interface fifo_uart_tx_if #(parameter int DATA_SIZE = 8);
    logic [DATA_SIZE-1:0] rdata;
    logic empty;
    logic rd_en;
    modport master(input rdata, empty, output rd_en);
    modport slave(output rdata, empty, input rd_en);
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: per-bit period counter with a bit-end tick, held at zero outside the bit-driving states
module baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    logic [BAUD_CNT_W-1:0] cnt;
    assign tick = run && cnt == BAUD_CNT_W'(CLKS_PER_BIT - 1);
    // count 0..CLKS_PER_BIT-1, restarting at every bit boundary and whenever the FSM is not driving a bit
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (!run || tick) ? '0 : cnt + BAUD_CNT_W'(1);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from a FIFO and sends them as UART frames; define FIFO_UART_TX_PARITY_EN for an even-parity bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_uart_tx_if.master         fifo,
    output logic                   tx,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam int BIT_W = $clog2(DATA_SIZE + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
    state_t state;
    logic [DATA_SIZE-1:0] shreg;
    logic [BIT_W-1:0] bit_idx;
    logic tick;
    logic run;
`ifdef FIFO_UART_TX_PARITY_EN
    logic par;
`endif
    assign run = state inside {START, DATA, PARITY, STOP};
    assign fifo.rd_en = !rst && state == IDLE && !fifo.empty;
    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .rst(rst),
        .run(run),
        .tick(tick)
    );
    // frame sequencer: the read strobe is issued from IDLE, data lands in LOAD, bits advance on each tick
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            busy <= 1'b0;
            frame_cnt <= '0;
            shreg <= '0;
            bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else
            case (state)
                IDLE: if (!fifo.empty) begin
                    state <= LOAD;
                    busy <= 1'b1;
                end
                LOAD: begin
                    state <= START;
                    tx <= 1'b0;
                    shreg <= fifo.rdata;
                    bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    par <= ^fifo.rdata;
`endif
                end
                START: if (tick) begin
                    state <= DATA;
                    tx <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (tick) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state <= PARITY;
                        tx <= par;
`else
                        state <= STOP;
                        tx <= 1'b1;
`endif
                    end else begin
                        tx <= shreg[0];
                        shreg <= shreg >> 1;
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
                PARITY: if (tick) begin
                    state <= STOP;
                    tx <= 1'b1;
                end
                STOP: if (tick) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
endmodule
